// File: rtl/fixed_pkg.sv
// Shared constants, FSM encoding and sign-magnitude helpers for the fixed-point divider.
package fixed_pkg;
  localparam int N = 32;
  localparam int Q = 16;
  localparam int W = N - 1;

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1} << Q;
  localparam logic [N-1:0] TWO      = ONE << 1;
  localparam logic [W-1:0] MAX_MAG  = '1;
  localparam logic [N-1:0] NEG_ZERO = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, SEED, MUL_DX, SUB, MUL_XS, FINAL, DONE
  } state_t;

  function automatic logic [N-1:0] sm_neg(input logic [N-1:0] v);
    return {~v[N-1], v[N-2:0]};
  endfunction
endpackage

// File: rtl/recip_seed.sv
// Reciprocal seed: power of two placing |b|*x0 in [0.5,1), clamped to the top magnitude bit.
module recip_seed
  import fixed_pkg::*;
(
  input  logic [W-1:0] b_mag,
  output logic [W-1:0] x0,
  output logic         clamp
);

  int p;
  int sh;

  always_comb begin
    p = 0;
    for (int i = 0; i < W; i++) begin
      if (b_mag[i]) p = i;
    end
    sh = 2 * Q - 1 - p;
    clamp = 1'b0;
    if (sh > W - 1) begin
      sh = W - 1;
      clamp = 1'b1;
    end
    if (sh < 0) sh = 0;
    x0 = {{(W-1){1'b0}}, 1'b1} << sh;
  end

endmodule

// File: rtl/fixed_div_sequencer.sv
// Sign-magnitude fixed-point a/b via Newton-Raphson on one shared multiplier and adder.
// Result 3*ITERS+2 edges after accept; one op in flight, result held until out_ready.
module fixed_div_sequencer
  import fixed_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic         out_dbz,
  output logic         out_ovf
);

  state_t       state;
  logic [W-1:0] a_mag, b_mag, x_mag, t_mag, s_mag;
  logic         sign_a, sign_q, dbz, seed_clamp;
  logic [3:0]   cnt;

  logic [W-1:0] seed_x0;
  logic         seed_clamp_c;

  recip_seed u_seed (
    .b_mag (b_mag),
    .x0    (seed_x0),
    .clamp (seed_clamp_c)
  );

  // Shared multiplier: operands chosen by state, product rescaled by Q and saturated.
  logic [N-1:0]   mul_a, mul_b, mul_res;
  logic [2*W-1:0] mul_prod, mul_shift;
  logic [W-1:0]   mul_mag;
  logic           mul_ovf;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_DX: begin mul_a = {1'b0, b_mag};  mul_b = {1'b0, x_mag}; end
      MUL_XS: begin mul_a = {1'b0, x_mag};  mul_b = {1'b0, s_mag}; end
      FINAL:  begin mul_a = {sign_q, a_mag}; mul_b = {1'b0, x_mag}; end
      default: ;
    endcase
    mul_prod  = {{W{1'b0}}, mul_a[W-1:0]} * {{W{1'b0}}, mul_b[W-1:0]};
    mul_shift = mul_prod >> Q;
    mul_ovf   = |mul_shift[2*W-1:W];
    mul_mag   = mul_ovf ? MAX_MAG : mul_shift[W-1:0];
    mul_res   = {mul_a[N-1] ^ mul_b[N-1], mul_mag};
  end

  // Shared sign-magnitude adder; a zero sum always comes out as +0.
  logic [N-1:0] add_a, add_b, add_res;
  logic [W:0]   add_sum;
  logic [W-1:0] add_mag;
  logic         add_sign;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == SUB) begin
      add_a = TWO;
      add_b = sm_neg({1'b0, t_mag});
    end
    add_sum  = {1'b0, add_a[W-1:0]} + {1'b0, add_b[W-1:0]};
    add_mag  = '0;
    add_sign = 1'b0;
    if (add_a[N-1] == add_b[N-1]) begin
      add_sign = add_a[N-1];
      add_mag  = add_sum[W] ? MAX_MAG : add_sum[W-1:0];
    end else if (add_a[W-1:0] >= add_b[W-1:0]) begin
      add_sign = add_a[N-1];
      add_mag  = add_a[W-1:0] - add_b[W-1:0];
    end else begin
      add_sign = add_b[N-1];
      add_mag  = add_b[W-1:0] - add_a[W-1:0];
    end
    add_res = {add_sign & (|add_mag), add_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_q      <= '0;
      out_dbz    <= 1'b0;
      out_ovf    <= 1'b0;
      a_mag      <= '0;
      b_mag      <= '0;
      x_mag      <= '0;
      t_mag      <= '0;
      s_mag      <= '0;
      sign_a     <= 1'b0;
      sign_q     <= 1'b0;
      dbz        <= 1'b0;
      seed_clamp <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_mag    <= in_a[W-1:0];
            b_mag    <= in_b[W-1:0];
            sign_a   <= in_a[N-1];
            sign_q   <= in_a[N-1] ^ in_b[N-1];
            dbz      <= (in_b[W-1:0] == '0);
            in_ready <= 1'b0;
            state    <= SEED;
          end
        end
        SEED: begin
          x_mag      <= seed_x0;
          seed_clamp <= seed_clamp_c;
          cnt        <= '0;
          state      <= MUL_DX;
        end
        MUL_DX: begin
          t_mag <= mul_res[W-1:0];
          state <= SUB;
        end
        SUB: begin
          // Keep the correction factor strictly positive so x never collapses to zero.
          if (add_res[N-1] || add_res[W-1:0] == '0)
            s_mag <= {{(W-1){1'b0}}, 1'b1};
          else
            s_mag <= add_res[W-1:0];
          state <= MUL_XS;
        end
        MUL_XS: begin
          x_mag <= mul_res[W-1:0];
          cnt   <= cnt + 4'd1;
          state <= (cnt == 4'(ITERS - 1)) ? FINAL : MUL_DX;
        end
        FINAL: begin
          if (dbz) begin
            out_q   <= {sign_a, MAX_MAG};
            out_ovf <= 1'b0;
          end else begin
            out_q   <= (mul_res == NEG_ZERO) ? '0 : mul_res;
            out_ovf <= mul_ovf | seed_clamp;
          end
          out_dbz   <= dbz;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
